// File: rtl/reaction_timing_unit.sv
// Timing datapath beside the reaction-test FSM: pseudo-random PREP delay,
// TEST window timeout, reaction-time capture and session-best tracking.
module reaction_timing_unit #(
    parameter int PREP_MIN_MS = 1000,
    parameter int TEST_MAX_MS = 1000,
    parameter int MS_WIDTH    = 14
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [2:0]          current_state,
    input  logic                rising_edge_1khz,
    output logic                prep_timeout,
    output logic                test_timeout,
    output logic [MS_WIDTH-1:0] reaction_ms,
    output logic                result_valid,
    output logic [MS_WIDTH-1:0] best_ms,
    output logic                best_valid,
    output logic                new_best
);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PREP        = 3'd1,
        ST_TEST        = 3'd2,
        ST_RESULT_OK   = 3'd3,
        ST_RESULT_FAIL = 3'd4
    } state_e;

    localparam logic [15:0]         LFSR_SEED = 16'hACE1;
    localparam logic [MS_WIDTH-1:0] PREP_MIN  = MS_WIDTH'(PREP_MIN_MS);
    localparam logic [MS_WIDTH-1:0] TEST_MAX  = MS_WIDTH'(TEST_MAX_MS);
    localparam logic [MS_WIDTH-1:0] CNT_MAX   = {MS_WIDTH{1'b1}};

    logic [2:0]          prev_state_q,   prev_state_d;
    logic [15:0]         lfsr_q,         lfsr_d;
    logic [MS_WIDTH-1:0] prep_cnt_q,     prep_cnt_d;
    logic [MS_WIDTH-1:0] prep_target_q,  prep_target_d;
    logic [MS_WIDTH-1:0] react_cnt_q,    react_cnt_d;
    logic [MS_WIDTH-1:0] reaction_ms_q,  reaction_ms_d;
    logic                result_valid_q, result_valid_d;
    logic [MS_WIDTH-1:0] best_ms_q,      best_ms_d;
    logic                best_valid_q,   best_valid_d;
    logic                new_best_q,     new_best_d;

    logic in_prep, in_test;
    logic prep_entry, test_entry, ok_entry, fail_entry;
    logic lfsr_fb;

    always_comb begin
        in_prep    = (current_state == ST_PREP);
        in_test    = (current_state == ST_TEST);
        prep_entry = in_prep && (prev_state_q != ST_PREP);
        test_entry = in_test && (prev_state_q != ST_TEST);
        ok_entry   = (current_state == ST_RESULT_OK)   && (prev_state_q != ST_RESULT_OK);
        fail_entry = (current_state == ST_RESULT_FAIL) && (prev_state_q != ST_RESULT_FAIL);
    end

    // Timeouts are masked on the entry cycle, when the counter and target
    // still hold values from the previous attempt.
    assign prep_timeout = in_prep && !prep_entry && (prep_cnt_q >= prep_target_q);
    assign test_timeout = in_test && !test_entry && (react_cnt_q >= TEST_MAX);

    // Right-shifting Fibonacci form of taps 16,14,13,11.
    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    // NOTE: every *_d gets a default before any condition, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        prev_state_d   = current_state;
        lfsr_d         = {lfsr_fb, lfsr_q[15:1]};
        prep_cnt_d     = prep_cnt_q;
        prep_target_d  = prep_target_q;
        react_cnt_d    = react_cnt_q;
        reaction_ms_d  = reaction_ms_q;
        result_valid_d = result_valid_q;
        best_ms_d      = best_ms_q;
        best_valid_d   = best_valid_q;
        new_best_d     = 1'b0;

        if (prep_entry) begin
            prep_target_d  = PREP_MIN + MS_WIDTH'(lfsr_q[10:0]);
            prep_cnt_d     = '0;
            result_valid_d = 1'b0;
        end else if (in_prep && rising_edge_1khz && (prep_cnt_q != CNT_MAX)) begin
            prep_cnt_d = prep_cnt_q + 1'b1;
        end

        // An entry coinciding with a tick restarts at 0; the tick is dropped.
        if (test_entry) begin
            react_cnt_d = '0;
        end else if (in_test && rising_edge_1khz && (react_cnt_q < TEST_MAX)) begin
            react_cnt_d = react_cnt_q + 1'b1;
        end

        if (ok_entry && (prev_state_q == ST_TEST)) begin
            reaction_ms_d  = react_cnt_q;
            result_valid_d = 1'b1;
            if (!best_valid_q || (react_cnt_q < best_ms_q)) begin
                best_ms_d    = react_cnt_q;
                best_valid_d = 1'b1;
                new_best_d   = 1'b1;
            end
        end

        if (fail_entry) begin
            reaction_ms_d  = '0;
            result_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_state_q   <= ST_IDLE;
            lfsr_q         <= LFSR_SEED;
            prep_cnt_q     <= '0;
            prep_target_q  <= '0;
            react_cnt_q    <= '0;
            reaction_ms_q  <= '0;
            result_valid_q <= 1'b0;
            best_ms_q      <= '0;
            best_valid_q   <= 1'b0;
            new_best_q     <= 1'b0;
        end else begin
            prev_state_q   <= prev_state_d;
            lfsr_q         <= lfsr_d;
            prep_cnt_q     <= prep_cnt_d;
            prep_target_q  <= prep_target_d;
            react_cnt_q    <= react_cnt_d;
            reaction_ms_q  <= reaction_ms_d;
            result_valid_q <= result_valid_d;
            best_ms_q      <= best_ms_d;
            best_valid_q   <= best_valid_d;
            new_best_q     <= new_best_d;
        end
    end

    assign reaction_ms  = reaction_ms_q;
    assign result_valid = result_valid_q;
    assign best_ms      = best_ms_q;
    assign best_valid   = best_valid_q;
    assign new_best     = new_best_q;

endmodule

// File: tb/tb_reaction_timing_unit.sv
// Directed self-checking bench for reaction_timing_unit; ticks are driven
// every clock so ms counts equal clock counts.
module tb_reaction_timing_unit;

    localparam int W = 14;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [2:0]   current_state = 3'd0;
    logic         rising_edge_1khz = 1'b0;
    logic         prep_timeout, test_timeout;
    logic [W-1:0] reaction_ms, best_ms;
    logic         result_valid, best_valid, new_best;

    localparam logic [2:0] IDLE = 3'd0, PREP = 3'd1, TEST = 3'd2,
                           R_OK = 3'd3, R_FAIL = 3'd4, ILLEGAL = 3'd5;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] m_lfsr   = 16'hACE1;

    reaction_timing_unit #(
        .PREP_MIN_MS(1000),
        .TEST_MAX_MS(1000),
        .MS_WIDTH   (W)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .current_state   (current_state),
        .rising_edge_1khz(rising_edge_1khz),
        .prep_timeout    (prep_timeout),
        .test_timeout    (test_timeout),
        .reaction_ms     (reaction_ms),
        .result_valid    (result_valid),
        .best_ms         (best_ms),
        .best_valid      (best_valid),
        .new_best        (new_best)
    );

    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] fb;
        fb = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 16'h0001;
        return (v >> 1) | (fb << 15);
    endfunction

    // One clock; outputs are sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clock);
        m_lfsr = reset ? 16'hACE1 : lfsr_step(m_lfsr);
        #1;
    endtask

    task automatic run_ticks(input int n);
        rising_edge_1khz = 1'b1;
        repeat (n) cyc();
        rising_edge_1khz = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_prep_to"}, prep_timeout, 0);
        check({tag, "_test_to"}, test_timeout, 0);
        check({tag, "_react"},   reaction_ms,  0);
        check({tag, "_rvalid"},  result_valid, 0);
        check({tag, "_best"},    best_ms,      0);
        check({tag, "_bvalid"},  best_valid,   0);
        check({tag, "_newbest"}, new_best,     0);
    endtask

    task automatic attempt(input int n, input logic tick_on_entry);
        current_state = IDLE; cyc();
        current_state = PREP; cyc();
        check("rvalid_clr_prep", result_valid, 0);
        current_state = TEST;
        rising_edge_1khz = tick_on_entry;
        cyc();
        rising_edge_1khz = 1'b0;
        run_ticks(n);
        current_state = R_OK; cyc();
    endtask

    initial begin
        int          bad;
        int          zeros;
        int          guard;
        logic [15:0] start;

        reset = 1'b1;
        repeat (2) cyc();
        check_all_zero("reset");
        check("lfsr_seed", dut.lfsr_q, 16'hACE1);
        reset = 1'b0;
        repeat (20) cyc();
        check_all_zero("idle20");

        bad = 0; zeros = 0; start = m_lfsr;
        for (int i = 0; i < 65535; i++) begin
            cyc();
            if (dut.lfsr_q !== m_lfsr) bad++;
            if (dut.lfsr_q == 16'h0000) zeros++;
        end
        check("lfsr_seq_errs", bad, 0);
        check("lfsr_zero_hits", zeros, 0);
        check("lfsr_period", dut.lfsr_q, start);

        // Enter PREP when lfsr[10:0] = 0x0E1, giving a 1225 ms target.
        guard = 0;
        while (m_lfsr[10:0] != 11'h0E1 && guard < 65536) begin
            cyc();
            guard++;
        end
        check("lfsr_search", m_lfsr[10:0], 11'h0E1);
        current_state = PREP; cyc();
        run_ticks(1224);
        check("prep_to_1224", prep_timeout, 0);
        run_ticks(1);
        check("prep_to_1225", prep_timeout, 1);
        current_state = TEST; #1;
        check("prep_to_leave", prep_timeout, 0);
        cyc();
        run_ticks(250);
        check("test_to_250", test_timeout, 0);
        current_state = R_OK; cyc();
        check("a1_react",   reaction_ms,  250);
        check("a1_rvalid",  result_valid, 1);
        check("a1_best",    best_ms,      250);
        check("a1_bvalid",  best_valid,   1);
        check("a1_newbest", new_best,     1);
        cyc();
        check("a1_newbest_off", new_best, 0);

        // Tick coincident with TEST entry must be dropped.
        attempt(300, 1'b1);
        check("a2_react",   reaction_ms,  300);
        check("a2_rvalid",  result_valid, 1);
        check("a2_best",    best_ms,      250);
        check("a2_newbest", new_best,     0);

        attempt(250, 1'b0);
        check("a3_react",   reaction_ms, 250);
        check("a3_best",    best_ms,     250);
        check("a3_newbest", new_best,    0);

        attempt(180, 1'b0);
        check("a4_react",   reaction_ms, 180);
        check("a4_best",    best_ms,     180);
        check("a4_newbest", new_best,    1);
        cyc();
        check("a4_newbest_off", new_best, 0);

        current_state = IDLE; cyc();
        current_state = PREP; cyc();
        current_state = TEST; cyc();
        run_ticks(999);
        check("test_to_999", test_timeout, 0);
        run_ticks(1);
        check("test_to_1000", test_timeout, 1);
        run_ticks(20);
        check("react_sat", dut.react_cnt_q, 1000);
        check("test_to_hold", test_timeout, 1);
        current_state = R_FAIL; cyc();
        check("fail_rvalid",  result_valid, 0);
        check("fail_react",   reaction_ms,  0);
        check("fail_best",    best_ms,      180);
        check("fail_bvalid",  best_valid,   1);
        check("fail_test_to", test_timeout, 0);

        current_state = IDLE; cyc();
        current_state = R_OK; cyc();
        check("ok_no_test_rvalid", result_valid, 0);
        check("ok_no_test_react",  reaction_ms,  0);
        check("ok_no_test_best",   best_ms,      180);
        check("ok_no_test_newbest", new_best,    0);

        current_state = ILLEGAL;
        run_ticks(3);
        check("illegal_prep_to", prep_timeout, 0);
        check("illegal_test_to", test_timeout, 0);
        check("illegal_hold",    dut.react_cnt_q, 1000);

        current_state = IDLE; cyc();
        current_state = PREP; cyc();
        current_state = TEST; cyc();
        run_ticks(400);
        check("mid_react_cnt", dut.react_cnt_q, 400);
        reset = 1'b1; cyc();
        check_all_zero("midreset");
        check("midreset_cnt", dut.react_cnt_q, 0);

        // First PREP entry after reset samples the seed: 1000 + 0x4E1 = 2249.
        reset = 1'b0;
        current_state = PREP; cyc();
        run_ticks(2248);
        check("seed_prep_2248", prep_timeout, 0);
        run_ticks(1);
        check("seed_prep_2249", prep_timeout, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reaction_timing_unit.md
Name: reaction_timing_unit

Overview:
- Timing datapath beside the test-sequencing FSM.
- Consumes the FSM's `current_state` and the 1 kHz tick.
- Generates a pseudo-random PREP delay and drives `prep_timeout` and `test_timeout` back into the FSM.
- Measures reaction time in ms during TEST, latches the result on a valid stop, and tracks the session best time for the display stage.

Parameters:
- PREP_MIN_MS, 1000, fixed minimum PREP delay in ms.
- TEST_MAX_MS, 1000, TEST window in ms; reaching it asserts `test_timeout`.
- MS_WIDTH, 14, width of all ms counters and results. Constraint: PREP_MIN_MS+2047 < 2^MS_WIDTH and TEST_MAX_MS < 2^MS_WIDTH.

Ports:
- clock  in  1  system clock. Reset: reset, synchronous, active-high; clock clock.
- reset  in  1  synchronous active-high reset.
- current_state  in  3  FSM state: IDLE=0, PREP=1, TEST=2, RESULT_OK=3, RESULT_FAIL=4.
- rising_edge_1khz  in  1  one-clock pulse per ms.
- prep_timeout  out  1  PREP delay expired.
- test_timeout  out  1  TEST window expired.
- reaction_ms  out  MS_WIDTH  last valid reaction time.
- result_valid  out  1  `reaction_ms` holds a result from the current attempt.
- best_ms  out  MS_WIDTH  lowest valid reaction since reset.
- best_valid  out  1  `best_ms` is meaningful.
- new_best  out  1  one-clock pulse when `best_ms` updates.

Behaviour:
- Reset: all outputs 0. Internal registers reset as follows:
  - prev_state = IDLE
  - prep_cnt, react_cnt, prep_target = 0
  - lfsr = 16'hACE1
- Reset mid-operation clears everything, including best.
- prev_state: registers `current_state` every clock. Entry into state S = (current_state==S && prev_state!=S).
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11, shifted every clock regardless of state.
  - Never zero, given the nonzero seed.
- PREP entry:
  - prep_target <= PREP_MIN_MS + lfsr[10:0], zero-extended to MS_WIDTH, giving a range of 1000..3047 ms at defaults.
  - prep_cnt <= 0; result_valid <= 0.
- PREP, not entry cycle: prep_cnt increments on rising_edge_1khz, saturating at all-ones.
- prep_timeout:
  - Combinational = (current_state==PREP) && (prep_cnt >= prep_target).
  - Expected first assertion: the clock after the prep_target-th tick.
- TEST entry: react_cnt <= 0.
- TEST, not entry cycle: react_cnt increments on rising_edge_1khz, saturating at TEST_MAX_MS.
- test_timeout: combinational = (current_state==TEST) && (react_cnt >= TEST_MAX_MS).
- Entry and tick in the same cycle: entry wins; the counter loads 0 and the tick is dropped.
- RESULT_OK entry with prev_state==TEST:
  - reaction_ms <= react_cnt; result_valid <= 1.
  - If !best_valid or react_cnt < best_ms: best_ms <= react_cnt, best_valid <= 1, new_best <= 1 for exactly one clock.
  - Equal time is not a new best.
- RESULT_FAIL entry: result_valid <= 0; reaction_ms <= 0; best unchanged.
- RESULT_OK entered from any state other than TEST: no latch, no best update.
- IDLE and RESULT states: prep_cnt and react_cnt hold their values. Timeouts are low.
- Illegal state codes (5–7): counters hold, both timeouts low, no latches.
- new_best is 0 on every cycle other than the update cycle.

Test Plan:
- Reset, then 20 IDLE clocks: all outputs 0; LFSR sequence starts 16'hACE1 and never hits 0 over 65535 clocks.
- PREP entry with lfsr[10:0]=16'h0E1 (225) → prep_target=1225. prep_timeout stays low through tick 1224 and goes high the clock after tick 1225. Leaving PREP drops it the same cycle.
- TEST entered, then 250 ticks, then RESULT_OK: reaction_ms=250, result_valid=1, best_ms=250, best_valid=1, new_best high for exactly 1 clock.
- Second attempt of 300 ms → best_ms stays 250, no new_best. Third attempt of 250 ms → no new_best. Fourth of 180 ms → best_ms=180 with new_best pulse.
- TEST held for 1000 ticks: test_timeout asserts after tick 1000 and react_cnt saturates at 1000. Then RESULT_FAIL: result_valid=0, reaction_ms=0, best unchanged.
- Tick coincident with TEST entry → count starts at 0. Reset asserted at react_cnt=400 → all outputs and best clear the next clock; following PREP entry loads a target from seed 16'hACE1.
